sram_bytemask: RTL and testbench
================================

Name: sram_bytemask

Overview:
- Parametrised synchronous data memory for the processor datapath; next generation of the single-port word SRAM.
- Adds byte addressing and byte/half/word(/dword) stores with lane masking.
- Loads are sign- or zero-extended; read latency is configurable.
- Misaligned or illegal accesses are flagged and suppressed.
- Sits between the ALU address output and the write-back mux.

Parameters:
- DATA_W, 32, word width in bits; legal values 32 or 64.
- DEPTH_LOG2, 8, log2 of the number of words (256 words default).
- RD_LAT, 1, read latency in cycles from accepted read to rvalid; legal values 1 or 2.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- cs  in  1  chip select; no access when 0
- addr  in  DEPTH_LOG2+log2(DATA_W/8)  byte address; low log2(DATA_W/8) bits are the byte offset
- wdata  in  DATA_W  store data, right-justified (byte in bits [7:0])
- we  in  1  write request
- re  in  1  read request
- size  in  2  access size: 0=byte, 1=half, 2=word(32b), 3=dword(64b)
- uns  in  1  loads only; 1=zero-extend, 0=sign-extend
- rdata  out  DATA_W  load result, extended, right-justified
- rvalid  out  1  one-cycle pulse, rdata valid
- err  out  1  one-cycle pulse, illegal access detected
- wr_done  out  1  one-cycle pulse, store committed

Behaviour:
- Reset (rst_n=0, asynchronous): rdata=0, rvalid=0, err=0, wr_done=0; read pipeline flushed. Memory array is not cleared and holds its contents across reset.
- Access accepted at a rising clk edge when cs=1 and (we|re)=1. With cs=0, inputs are ignored and no pulses are generated.
- Priority: we=1 and re=1 in the same cycle is treated as a write only (re ignored), as in the previous SRAM.
- Legality:
  - size encodes 2^size bytes.
  - Illegal if 2^size > DATA_W/8 (size=3 with DATA_W=32).
  - Illegal if the addr offset is not a multiple of 2^size.
- Illegal write: memory unchanged; err=1 and wr_done=0 on the cycle after the edge.
- Illegal read: err=1 and rvalid=1 exactly RD_LAT cycles after acceptance, with rdata=0. The pipeline slot is kept so ordering is preserved.
- Legal write:
  - word index = addr[MSB:off_bits]; lanes written are [offset .. offset+2^size-1].
  - wdata bytes [0..2^size-1] go to those lanes; all other lanes are untouched.
  - Committed at the accepting edge; wr_done=1 on the following cycle.
- Legal read:
  - Word read at the accepting edge; bytes extracted from lane offset.
  - Result is extended to DATA_W from bit (8*2^size-1), using the sign of that bit unless uns=1. A full-width read is passed unchanged.
  - RD_LAT=1: rdata/rvalid registered at the accept edge, visible the next cycle.
  - RD_LAT=2: one additional output register stage.
- Reads are fully pipelined: one read per cycle is accepted with no stalls, and results return in order.
- rdata holds its last value when rvalid=0. It is cleared only by reset or by an illegal read result.
- Read-after-write: a write at edge N followed by a read of the same word at edge N+1 returns the new data.
- Same-cycle we+re: the read is dropped; no rvalid is generated for it.
- Reset asserted mid-pipeline: in-flight reads are discarded and no rvalid/err appears after reset release. A write accepted before reset assertion remains in memory.
- Address wrap: none. The full word index range is addressed, so every addr maps to a valid word.

Test Plan:
- DATA_W=32, RD_LAT=1: word write 0xDEADBEEF @0x10, then byte read @0x13 uns=0 -> one cycle later rvalid=1, rdata=0xFFFFFFDE. Same read with uns=1 -> 0x000000DE.
- Half store 0x1234 @0x22 over a word holding 0xAAAAAAAA, then word read @0x20 -> 0x1234AAAA. wr_done pulses once for the store.
- Misaligned half read @0x21 -> rvalid=1, err=1, rdata=0. Misaligned word write @0x06 -> err=1, word @0x04 unchanged.
- RD_LAT=2: back-to-back reads @0x00, 0x04, 0x08 on consecutive cycles -> three rvalid pulses on consecutive cycles, beginning 2 cycles after the first accept, data returned in order.
- we=re=1 @0x30 with wdata=0x55 (word) -> write occurs, no rvalid. A read next cycle returns 0x00000055. cs=0 write -> memory unchanged, no pulses.
- rst_n pulsed low between accepting a read and its return (RD_LAT=2) -> outputs 0 immediately, no rvalid after release. Memory contents written earlier still read back correctly.

Source files
------------

// File: rtl/sram_bytemask.sv
`default_nettype none
// ============================================================================
//  Module   : sram_bytemask
//  Purpose  : Byte-addressed synchronous data memory with lane-masked stores,
//             sign/zero-extended loads and a 1- or 2-cycle read pipeline.
//  Revision : 1.0  initial release
// ============================================================================
module sram_bytemask #(
  parameter int DATA_W     = 32,
  parameter int DEPTH_LOG2 = 8,
  parameter int RD_LAT     = 1
) (
  input  logic                                       clk,
  input  logic                                       rst_n,
  input  logic                                       cs,
  input  logic [DEPTH_LOG2+$clog2(DATA_W/8)-1:0]     addr,
  input  logic [DATA_W-1:0]                          wdata,
  input  logic                                       we,
  input  logic                                       re,
  input  logic [1:0]                                 size,
  input  logic                                       uns,
  output logic [DATA_W-1:0]                          rdata,
  output logic                                       rvalid,
  output logic                                       err,
  output logic                                       wr_done
);

  localparam int         NB       = DATA_W / 8;
  localparam int         OFF_W    = $clog2(NB);
  localparam int         AW       = DEPTH_LOG2 + OFF_W;
  localparam int         WORDS    = 1 << DEPTH_LOG2;
  localparam logic [1:0] MAX_SIZE = 2'(OFF_W);

  logic [DATA_W-1:0] mem [WORDS];

  logic [DEPTH_LOG2-1:0] w_idx;
  logic [OFF_W-1:0]      w_off;
  logic [2:0]            w_off3;
  logic [2:0]            w_amask;
  logic [3:0]            w_nbytes;
  logic                  w_illegal;
  logic                  w_acc;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_wr_ok;
  logic [NB-1:0]         w_wmask;
  logic [NB-1:0]         w_rmask;
  logic [DATA_W-1:0]     w_wsh;
  logic [DATA_W-1:0]     w_rsh;
  logic                  w_sign;
  logic                  w_fill;
  logic [DATA_W-1:0]     w_ext;
  logic [DATA_W-1:0]     w_rres;

  assign w_idx    = addr[AW-1:OFF_W];
  assign w_off    = addr[OFF_W-1:0];
  assign w_off3   = 3'(w_off);
  assign w_nbytes = 4'd1 << size;

  always_comb begin
    w_amask = 3'b000;
    case (size)
      2'd0:    w_amask = 3'b000;
      2'd1:    w_amask = 3'b001;
      2'd2:    w_amask = 3'b011;
      default: w_amask = 3'b111;
    endcase
  end

  assign w_illegal = (size > MAX_SIZE) | (|(w_off3 & w_amask));

  // Gating with rst_n keeps a store issued during reset out of the array.
  assign w_acc   = cs & rst_n;
  assign w_wr    = w_acc & we;
  assign w_rd    = w_acc & re & ~we;
  assign w_wr_ok = w_wr & ~w_illegal;

  always_comb begin
    w_wmask = '0;
    w_rmask = '0;
    for (int i = 0; i < NB; i++) begin
      w_rmask[i] = (i < int'(w_nbytes));
      w_wmask[i] = (i >= int'(w_off3)) && (i < int'(w_off3) + int'(w_nbytes));
    end
  end

  assign w_wsh = wdata << {w_off3, 3'b000};
  assign w_rsh = mem[w_idx] >> {w_off3, 3'b000};

  always_comb begin
    w_sign = 1'b0;
    case (size)
      2'd0:    w_sign = w_rsh[7];
      2'd1:    w_sign = w_rsh[15];
      2'd2:    w_sign = w_rsh[31];
      default: w_sign = w_rsh[DATA_W-1];
    endcase
  end

  assign w_fill = w_sign & ~uns;

  always_comb begin
    w_ext = '0;
    for (int i = 0; i < NB; i++) begin
      w_ext[8*i +: 8] = w_rmask[i] ? w_rsh[8*i +: 8] : {8{w_fill}};
    end
  end

  assign w_rres = w_illegal ? '0 : w_ext;

  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      for (int i = 0; i < NB; i++) begin
        if (w_wmask[i]) mem[w_idx][8*i +: 8] <= w_wsh[8*i +: 8];
      end
    end
  end

  logic              r_v1;
  logic              r_e1;
  logic [DATA_W-1:0] r_d1;
  logic              r_wr_done;
  logic              r_werr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1      <= 1'b0;
      r_e1      <= 1'b0;
      r_d1      <= '0;
      r_wr_done <= 1'b0;
      r_werr    <= 1'b0;
    end else begin
      r_v1      <= w_rd;
      r_e1      <= w_rd & w_illegal;
      r_wr_done <= w_wr_ok;
      r_werr    <= w_wr & w_illegal;
      if (w_rd) r_d1 <= w_rres;
    end
  end

  logic              w_v;
  logic              w_e;
  logic [DATA_W-1:0] w_d;

  generate
    if (RD_LAT == 2) begin : g_lat2
      logic              r_v2;
      logic              r_e2;
      logic [DATA_W-1:0] r_d2;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_v2 <= 1'b0;
          r_e2 <= 1'b0;
          r_d2 <= '0;
        end else begin
          r_v2 <= r_v1;
          r_e2 <= r_e1;
          if (r_v1) r_d2 <= r_d1;
        end
      end

      assign w_v = r_v2;
      assign w_e = r_e2;
      assign w_d = r_d2;
    end else begin : g_lat1
      assign w_v = r_v1;
      assign w_e = r_e1;
      assign w_d = r_d1;
    end
  endgenerate

  assign rvalid  = w_v;
  assign err     = w_e | r_werr;
  assign rdata   = w_d;
  assign wr_done = r_wr_done;

endmodule
`default_nettype wire

// File: tb/tb_sram_bytemask.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sram_bytemask
//  Purpose  : Directed bench driving RD_LAT=1 and RD_LAT=2 instances in step.
//  Revision : 1.1  checking task and watchdog
// ============================================================================
module tb_sram_bytemask;

    logic        clk;
    logic        rst_n;
    logic        cs;
    logic [9:0]  addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic [1:0]  size;
    logic        uns;

    logic [31:0] rdata1, rdata2;
    logic        rvalid1, rvalid2;
    logic        err1, err2;
    logic        wr_done1, wr_done2;

    int ncmp = 0;
    int nerr = 0;
    logic r_done = 1'b0;

    sram_bytemask #(.DATA_W(32), .DEPTH_LOG2(8), .RD_LAT(1)) u_l1 (
        .clk(clk), .rst_n(rst_n), .cs(cs), .addr(addr), .wdata(wdata),
        .we(we), .re(re), .size(size), .uns(uns),
        .rdata(rdata1), .rvalid(rvalid1), .err(err1), .wr_done(wr_done1)
    );

    sram_bytemask #(.DATA_W(32), .DEPTH_LOG2(8), .RD_LAT(2)) u_l2 (
        .clk(clk), .rst_n(rst_n), .cs(cs), .addr(addr), .wdata(wdata),
        .we(we), .re(re), .size(size), .uns(uns),
        .rdata(rdata2), .rvalid(rvalid2), .err(err2), .wr_done(wr_done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        if (obs !== exp) begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic acc(input logic c, input logic w, input logic r,
                       input logic [1:0] sz, input logic u,
                       input logic [9:0] a, input logic [31:0] d);
        cs = c; we = w; re = r; size = sz; uns = u; addr = a; wdata = d;
        @(posedge clk);
        #1;
        cs = 1'b0; we = 1'b0; re = 1'b0;
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        if (!r_done) begin
            nerr++;
            $error("FAIL timeout: directed sequence did not complete");
            $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
            $finish;
        end
    end

    initial begin
        rst_n = 1'b1; cs = 1'b0; we = 1'b0; re = 1'b0;
        size = 2'd0; uns = 1'b0; addr = '0; wdata = '0;
        #3 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rvalid1", rvalid1, 1'b0);
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_err1", err1, 1'b0);
        chk("rst_wr_done1", wr_done1, 1'b0);
        chk("rst_rdata2", rdata2, 32'h0);
        rst_n = 1'b1;
        idle();

        // Word store then signed / unsigned byte loads from the top lane
        acc(1, 1, 0, 2'd2, 0, 10'h010, 32'hDEADBEEF);
        chk("wr_word_done", wr_done1, 1'b1);
        chk("wr_word_err", err1, 1'b0);
        acc(1, 0, 1, 2'd0, 0, 10'h013, 32'h0);
        chk("lb_rvalid", rvalid1, 1'b1);
        chk("lb_signed", rdata1, 32'hFFFFFFDE);
        chk("wr_done_pulse", wr_done1, 1'b0);
        acc(1, 0, 1, 2'd0, 1, 10'h013, 32'h0);
        chk("lbu_unsigned", rdata1, 32'h000000DE);
        chk("l2_lb_rvalid", rvalid2, 1'b1);
        chk("l2_lb_signed", rdata2, 32'hFFFFFFDE);
        idle();
        chk("idle_rvalid1", rvalid1, 1'b0);
        chk("hold_rdata1", rdata1, 32'h000000DE);
        chk("l2_lbu", rdata2, 32'h000000DE);

        // Half store into upper lanes of a known word
        acc(1, 1, 0, 2'd2, 0, 10'h020, 32'hAAAAAAAA);
        acc(1, 1, 0, 2'd1, 0, 10'h022, 32'hFFFF1234);
        chk("sh_done", wr_done1, 1'b1);
        idle();
        chk("sh_done_once", wr_done1, 1'b0);
        acc(1, 0, 1, 2'd2, 0, 10'h020, 32'h0);
        chk("sh_merge", rdata1, 32'h1234AAAA);
        acc(1, 0, 1, 2'd0, 0, 10'h021, 32'h0);
        chk("lb_lane1", rdata1, 32'hFFFFFFAA);
        acc(1, 0, 1, 2'd1, 0, 10'h022, 32'h0);
        chk("lh_pos", rdata1, 32'h00001234);

        // Illegal accesses
        acc(1, 0, 1, 2'd1, 0, 10'h021, 32'h0);
        chk("mis_rd_rvalid", rvalid1, 1'b1);
        chk("mis_rd_err", err1, 1'b1);
        chk("mis_rd_data", rdata1, 32'h0);
        acc(1, 1, 0, 2'd2, 0, 10'h004, 32'h11223344);
        acc(1, 1, 0, 2'd2, 0, 10'h006, 32'hCAFEF00D);
        chk("mis_wr_err", err1, 1'b1);
        chk("mis_wr_done", wr_done1, 1'b0);
        acc(1, 0, 1, 2'd2, 0, 10'h004, 32'h0);
        chk("mis_wr_unchanged", rdata1, 32'h11223344);
        chk("legal_rd_err", err1, 1'b0);
        acc(1, 0, 1, 2'd3, 0, 10'h008, 32'h0);
        chk("dword_err", err1, 1'b1);
        chk("dword_rvalid", rvalid1, 1'b1);
        chk("dword_data", rdata1, 32'h0);

        // Back-to-back reads through the two-stage pipeline
        acc(1, 1, 0, 2'd2, 0, 10'h000, 32'hA0A0A0A0);
        acc(1, 1, 0, 2'd2, 0, 10'h008, 32'hC0C0C0C0);
        acc(1, 0, 1, 2'd2, 0, 10'h000, 32'h0);
        chk("b2b_lat_0", rvalid2, 1'b0);
        acc(1, 0, 1, 2'd2, 0, 10'h004, 32'h0);
        chk("b2b_v0", rvalid2, 1'b1);
        chk("b2b_d0", rdata2, 32'hA0A0A0A0);
        acc(1, 0, 1, 2'd2, 0, 10'h008, 32'h0);
        chk("b2b_v1", rvalid2, 1'b1);
        chk("b2b_d1", rdata2, 32'h11223344);
        idle();
        chk("b2b_v2", rvalid2, 1'b1);
        chk("b2b_d2", rdata2, 32'hC0C0C0C0);
        idle();
        chk("b2b_end", rvalid2, 1'b0);

        // Simultaneous we/re is a write only; deselected write is ignored
        acc(1, 1, 1, 2'd2, 0, 10'h030, 32'h00000055);
        chk("wr_rd_done", wr_done1, 1'b1);
        chk("wr_rd_no_rvalid", rvalid1, 1'b0);
        acc(1, 0, 1, 2'd2, 0, 10'h030, 32'h0);
        chk("wr_rd_data", rdata1, 32'h00000055);
        chk("l2_wr_rd_no_rvalid", rvalid2, 1'b0);
        acc(0, 1, 0, 2'd2, 0, 10'h030, 32'h00000099);
        chk("cs0_done", wr_done1, 1'b0);
        chk("cs0_err", err1, 1'b0);
        acc(1, 0, 1, 2'd2, 0, 10'h030, 32'h0);
        chk("cs0_unchanged", rdata1, 32'h00000055);

        // Reset while a read is in flight
        acc(1, 0, 1, 2'd2, 0, 10'h010, 32'h0);
        #1 rst_n = 1'b0;
        #1;
        chk("mid_rst_rvalid1", rvalid1, 1'b0);
        chk("mid_rst_rdata1", rdata1, 32'h0);
        chk("mid_rst_rdata2", rdata2, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle();
        chk("post_rst_rvalid2", rvalid2, 1'b0);
        chk("post_rst_err2", err2, 1'b0);
        idle();
        chk("post_rst_rvalid2b", rvalid2, 1'b0);
        acc(1, 0, 1, 2'd2, 0, 10'h010, 32'h0);
        chk("post_rst_mem1", rdata1, 32'hDEADBEEF);
        idle();
        chk("post_rst_mem2", rdata2, 32'hDEADBEEF);

        r_done = 1'b1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
`default_nettype wire
